// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator for a word-wide byte-enabled RAM; define LSU_MISALIGN_EN for misaligned and word-crossing accesses
module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_access,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [2:0] {IDLE, ACC0, CAP0, ACC1, CAP1, RESP} state_t;
    state_t state, nxt;
    logic we_q, split, legal, misal, req_err, nxt_err, unused_bits;
    logic [2:0] acc_q;
    logic [1:0] off_q;
    logic [ADDR_WIDTH-1:0] w0_q;
    logic [31:0] wdata_q, lo_q, lo_v, hi_v, x, ext, nxt_rdata;
    logic [3:0] ones;
    logic [7:0] be8;
    logic [63:0] sd;
    assign legal = req_access[1:0] != 2'b11 && !(req_access[2] && (req_we || req_access[1]));
`ifdef LSU_MISALIGN_EN
    logic [2:0] req_n;
    logic req_split;
    assign req_n = req_access[1] ? 3'd4 : req_access[0] ? 3'd2 : 3'd1;
    assign req_split = {1'b0, req_addr[1:0]} + req_n > 3'd4;
    assign misal = 1'b0;
    assign hi_v = state == CAP1 ? mem_rdata : '0;
    always_ff @(posedge clk) begin
        if (rst) split <= 1'b0;
        else if (req_valid && req_ready) split <= req_split;
    end
`else
    assign misal = (req_access[0] & req_addr[0]) | (req_access[1] & |req_addr[1:0]);
    assign split = 1'b0;
    assign hi_v = '0;
`endif
    assign unused_bits = ^{req_addr[31:ADDR_WIDTH+2], be8[7:4], sd[63:32]};
    assign req_err = !legal || misal;
    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;
    // byte lanes and store data for both words of a possibly split access
    assign ones = acc_q[1] ? 4'hf : acc_q[0] ? 4'h3 : 4'h1;
    assign be8 = {4'h0, ones} << off_q;
    assign sd = {32'h0, wdata_q} << {off_q, 3'b000};
    assign lo_v = state == CAP0 ? mem_rdata : lo_q;
    assign x = 32'({hi_v, lo_v} >> {off_q, 3'b000});
    assign ext = acc_q[1] ? x : acc_q[0] ? {{16{~acc_q[2] & x[15]}}, x[15:0]} : {{24{~acc_q[2] & x[7]}}, x[7:0]};
    always_comb begin
        nxt = state;
        nxt_err = 1'b0;
        nxt_rdata = '0;
        mem_addr = '0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        mem_be = '0;
        mem_wdata = '0;
        case (state)
            IDLE: if (req_valid) begin
                nxt = req_err ? RESP : ACC0;
                nxt_err = req_err;
            end
            ACC0: begin
                mem_addr = w0_q;
                mem_re = !we_q;
                mem_we = we_q;
                mem_be = we_q ? be8[3:0] : '0;
                mem_wdata = we_q ? sd[31:0] : '0;
                nxt = !we_q ? CAP0 : split ? ACC1 : RESP;
            end
            CAP0: begin
                nxt = split ? ACC1 : RESP;
                nxt_rdata = ext;
            end
`ifdef LSU_MISALIGN_EN
            ACC1: begin
                mem_addr = w0_q + ADDR_WIDTH'(1);
                mem_re = !we_q;
                mem_we = we_q;
                mem_be = we_q ? be8[7:4] : '0;
                mem_wdata = we_q ? sd[63:32] : '0;
                nxt = we_q ? RESP : CAP1;
            end
            CAP1: begin
                nxt = RESP;
                nxt_rdata = ext;
            end
`endif
            RESP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            we_q <= 1'b0;
            acc_q <= '0;
            off_q <= '0;
            w0_q <= '0;
            wdata_q <= '0;
            lo_q <= '0;
        end else begin
            state <= nxt;
            resp_rdata <= nxt == RESP ? nxt_rdata : '0;
            resp_err <= nxt_err;
            if (req_valid && req_ready) begin
                we_q <= req_we;
                acc_q <= req_access;
                off_q <= req_addr[1:0];
                w0_q <= req_addr[ADDR_WIDTH+1:2];
                wdata_q <= req_wdata;
            end
            if (state == CAP0) lo_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed table, corner sequences and random traffic against a byte-array memory model
module tb_lsu_mem_initiator;
`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    typedef struct {
        bit          we;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } vec_t;

    logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
    logic [2:0] req_access = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic req_ready, resp_valid, resp_err, mem_re, mem_we;
    logic [31:0] resp_rdata, mem_wdata;
    logic [10:0] mem_addr;
    logic [3:0] mem_be;

    lsu_mem_initiator dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_access(req_access), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM behaviour seen by the DUT, plus strobe counters
    logic [31:0] ram [0:2047];
    logic poke_en = 0;
    logic [10:0] poke_a = 0;
    logic [31:0] poke_d = 0;
    int nre = 0, nwe = 0, nboth = 0;
    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        if (mem_we) for (int i = 0; i < 4; i++) if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (mem_re) mem_rdata <= ram[mem_addr];
        nre <= nre + int'(mem_re);
        nwe <= nwe + int'(mem_we);
        nboth <= nboth + int'(mem_re & mem_we);
    end

    // reference model: plain byte-addressed memory
    logic [7:0] mb [0:8191];
    int errors = 0, checks = 0;

    function automatic int m_n(input logic [2:0] acc);
        return acc[1] ? 4 : acc[0] ? 2 : 1;
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] acc, input logic [31:0] a);
        bit legal = we ? acc inside {3'd0, 3'd1, 3'd2} : acc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bit unaligned = (int'(a[1:0]) % m_n(acc)) != 0;
        return !legal || (!MIS && unaligned);
    endfunction

    function automatic bit m_split(input logic [2:0] acc, input logic [31:0] a);
        return int'(a[1:0]) + m_n(acc) > 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] acc, input logic [31:0] a);
        logic [31:0] v = 0;
        for (int i = 0; i < m_n(acc); i++) v[8*i +: 8] = mb[(int'(a[12:0]) + i) % 8192];
        if (acc == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (acc == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic m_store(input logic [2:0] acc, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < m_n(acc); i++) mb[(int'(a[12:0]) + i) % 8192] = d[8*i +: 8];
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        poke_en = 1;
        poke_a = 11'(w);
        poke_d = v;
        for (int i = 0; i < 4; i++) mb[4*w + i] = v[8*i +: 8];
        @(negedge clk);
        poke_en = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one transaction, started at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic do_req(input bit we, input logic [2:0] acc, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output logic [31:0] rd, output logic er, output int lat,
                          output int dr, output int dw);
        int r0, w0;
        bit e = m_err(we, acc, a);
        req_valid = 1; req_we = we; req_access = acc; req_addr = a; req_wdata = d;
        r0 = nre; w0 = nwe;
        @(posedge clk);
        @(negedge clk);
        req_valid = hold; req_we = 1'($urandom); req_access = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata; er = resp_err; dr = nre - r0; dw = nwe - w0;
        req_valid = 0;
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 0);
        if (we && !e) m_store(acc, a, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[17];
        logic [31:0] rd, a, d, exp_rd;
        logic er;
        logic [2:0] acc;
        bit we, e, s;
        int lat, dr, dw, bad;
        vt[0]  = '{0, 3'd0, 32'h16, 0, 32'hFFFFFF99, 0, 3};
        vt[1]  = '{0, 3'd4, 32'h16, 0, 32'h00000099, 0, 3};
        vt[2]  = '{1, 3'd0, 32'h13, 32'h000000C3, 0, 0, 2};
        vt[3]  = '{0, 3'd2, 32'h10, 0, 32'hC3223344, 0, 3};
        vt[4]  = '{0, 3'd5, 32'h22, 0, 32'h0000F00D, 0, 3};
        vt[5]  = '{0, 3'd1, 32'h22, 0, 32'hFFFFF00D, 0, 3};
        vt[6]  = '{0, 3'd2, 32'h02, 0, MIS ? 32'h66554433 : 32'h0, !MIS, MIS ? 5 : 1};
        vt[7]  = '{0, 3'd1, 32'h01, 0, MIS ? 32'h00003322 : 32'h0, !MIS, MIS ? 3 : 1};
        vt[8]  = '{0, 3'd1, 32'h03, 0, MIS ? 32'h00005544 : 32'h0, !MIS, MIS ? 5 : 1};
        vt[9]  = '{0, 3'd2, 32'h00, 0, 32'h44332211, 0, 3};
        vt[10] = '{0, 3'd3, 32'h40, 0, 0, 1, 1};
        vt[11] = '{0, 3'd6, 32'h40, 0, 0, 1, 1};
        vt[12] = '{1, 3'd4, 32'h40, 32'h12345678, 0, 1, 1};
        vt[13] = '{1, 3'd3, 32'h40, 32'h12345678, 0, 1, 1};
        vt[14] = '{1, 3'd1, 32'h06, 32'h1234ABCD, 0, 0, 2};
        vt[15] = '{0, 3'd2, 32'h04, 0, 32'hABCD6655, 0, 3};
        vt[16] = '{0, 3'd2, 32'hFFFFE010, 0, 32'hC3223344, 0, 3};

        @(negedge clk);
        for (int w = 0; w < 2048; w++) poke(w, $urandom);
        poke(5, 32'h8899AABB);
        poke(4, 32'h11223344);
        poke(8, 32'hF00D1234);
        poke(0, 32'h44332211);
        poke(1, 32'h88776655);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_ctl", {25'b0, resp_valid, resp_err, mem_re, mem_we, mem_be}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_addr", 32'(mem_addr), 0);

        for (int i = 0; i < 17; i++) begin
            do_req(vt[i].we, vt[i].acc, vt[i].addr, vt[i].wdata, 1'b0, rd, er, lat, dr, dw);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
        end

        // LB strobe timing
        req_valid = 1; req_we = 0; req_access = 3'd0; req_addr = 32'h16;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("lb_mem_re", 32'(mem_re), 1);
        chk("lb_mem_addr", 32'(mem_addr), 5);
        @(negedge clk);
        @(negedge clk);
        chk("lb_resp", {resp_valid, resp_err}, 2'b10);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF99);
        @(negedge clk);

        // SB lane placement
        req_valid = 1; req_we = 1; req_access = 3'd0; req_addr = 32'h13; req_wdata = 32'hC3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("sb_strobes", {mem_re, mem_we}, 2'b01);
        chk("sb_addr", 32'(mem_addr), 4);
        chk("sb_be", 32'(mem_be), 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hC3000000);
        @(negedge clk);
        chk("sb_resp", {resp_valid, mem_we}, 2'b10);
        chk("sb_rdata", resp_rdata, 0);
        m_store(3'd0, 32'h13, 32'hC3);
        @(negedge clk);

        // SW crossing the top of memory
        req_valid = 1; req_we = 1; req_access = 3'd2; req_addr = 32'h1FFF; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
`ifdef LSU_MISALIGN_EN
        chk("sw_w0_addr", 32'(mem_addr), 2047);
        chk("sw_w0_be", 32'(mem_be), 4'b1000);
        chk("sw_w0_wdata", mem_wdata, 32'hEF000000);
        @(negedge clk);
        chk("sw_w1_addr", 32'(mem_addr), 0);
        chk("sw_w1_be", 32'(mem_be), 4'b0111);
        chk("sw_w1_wdata", mem_wdata, 32'h00DEADBE);
        @(negedge clk);
        chk("sw_resp", {resp_valid, resp_err}, 2'b10);
        m_store(3'd2, 32'h1FFF, 32'hDEADBEEF);
`else
        chk("sw_err", {resp_valid, resp_err, mem_we}, 3'b110);
`endif
        @(negedge clk);

        // illegal code with req_valid held: second accept two cycles later
        req_valid = 1; req_we = 0; req_access = 3'd3; req_addr = 0;
        @(posedge clk);
        @(negedge clk);
        chk("ill_resp1", {resp_valid, resp_err, req_ready}, 3'b110);
        @(negedge clk);
        chk("ill_gap", {resp_valid, req_ready}, 2'b01);
        @(negedge clk);
        chk("ill_resp2", {resp_valid, resp_err}, 2'b11);
        req_valid = 0;
        @(negedge clk);

        // reset while waiting for load data
        req_valid = 1; req_we = 0; req_access = 3'd2; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstc_ctl", {25'b0, resp_valid, resp_err, mem_re, mem_we, mem_be}, 0);
        chk("rstc_rdata", resp_rdata, 0);
        chk("rstc_wdata", mem_wdata, 0);
        chk("rstc_ready", 32'(req_ready), 1);
        @(negedge clk);
        chk("rstc_no_resp", 32'(resp_valid), 0);

        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom_range(0, 1));
            acc = 3'($urandom_range(0, 7));
            a = $urandom;
            d = $urandom;
            if (k % 2 == 1) a[12:4] = (k % 4 == 1) ? 9'h1FF : 9'h000;
            e = m_err(we, acc, a);
            s = m_split(acc, a);
            exp_rd = (e || we) ? 32'h0 : m_load(acc, a);
            do_req(we, acc, a, d, 1'($urandom_range(0, 1)), rd, er, lat, dr, dw);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_err", 32'(er), 32'(e));
            chk("rnd_lat", lat, e ? 1 : we ? (s ? 3 : 2) : (s ? 5 : 3));
            chk("rnd_reads", dr, (!e && !we) ? (s ? 2 : 1) : 0);
            chk("rnd_writes", dw, (!e && we) ? (s ? 2 : 1) : 0);
        end

        bad = 0;
        for (int w = 0; w < 2048; w++)
            if ({mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]} !== ram[w]) bad++;
        chk("ram_image", bad, 0);
        chk("re_we_exclusive", nboth, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
